// File: rtl/conv_image_buffer.sv
// conv_image_buffer: single-frame signed pixel store.
// A valid/ready byte stream fills the array in raster order. Once the frame is
// complete it is held (frame_ready=1) until conv control pulses release_frame.
// Two combinational read ports serve the patch loader. Addresses past the frame
// read back as zero, which the loader uses as padding.
module conv_image_buffer #(
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28,
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic signed [DATA_W-1:0] in_data,
    input  logic                     in_valid,
    input  logic                     in_last,
    output logic                     in_ready,
    output logic                     frame_ready,
    output logic                     frame_err,
    output logic        [ADDR_W-1:0] wr_count,
    input  logic                     release_frame,
    input  logic        [ADDR_W-1:0] addr1,
    input  logic        [ADDR_W-1:0] addr2,
    output logic signed [DATA_W-1:0] data1,
    output logic signed [DATA_W-1:0] data2
);

    localparam int NPIX = IMG_W * IMG_H;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NPIX - 1);

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_FILL,
        ST_FULL
    } state_t;

    state_t              state_q;
    logic                in_ready_q;
    logic                frame_ready_q;
    logic                frame_err_q;
    logic [ADDR_W-1:0]   wr_count_q;
    logic [ADDR_W-1:0]   wr_count_d;

    // Pixel storage; deliberately not reset so it maps onto block RAM.
    logic signed [DATA_W-1:0] mem [0:NPIX-1];

    logic accept;
    logic at_last;
    logic final_beat;
    logic beat_err;

    // in_ready_q is only ever high in EMPTY/FILL, so it alone gates writes.
    assign accept     = in_valid && in_ready_q;
    assign at_last    = (wr_count_q == LAST_IDX);
    assign final_beat = in_last || at_last;
    // in_last too early, or missing on the last slot of the frame.
    assign beat_err   = (in_last != at_last);
    assign wr_count_d = wr_count_q + ADDR_W'(1);

    // Frame state machine with registered handshake/status outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_EMPTY;
            wr_count_q    <= '0;
            in_ready_q    <= 1'b0;
            frame_ready_q <= 1'b0;
            frame_err_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_EMPTY, ST_FILL: begin
                    // Also raises in_ready on the first edge after reset.
                    in_ready_q <= 1'b1;
                    if (accept) begin
                        wr_count_q <= wr_count_d;
                        if (final_beat) begin
                            state_q       <= ST_FULL;
                            in_ready_q    <= 1'b0;
                            frame_ready_q <= 1'b1;
                            if (beat_err) begin
                                frame_err_q <= 1'b1;
                            end
                        end else begin
                            state_q <= ST_FILL;
                        end
                    end
                end
                ST_FULL: begin
                    if (release_frame) begin
                        state_q       <= ST_EMPTY;
                        wr_count_q    <= '0;
                        frame_err_q   <= 1'b0;
                        in_ready_q    <= 1'b1;
                        frame_ready_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_EMPTY;
                end
            endcase
        end
    end

    // Write port: one pixel per accepted beat at the current fill position.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_count_q] <= in_data;
        end
    end

    // Combinational reads give old data on a same-cycle write; out of range reads zero.
    assign data1 = (addr1 <= LAST_IDX) ? mem[addr1] : '0;
    assign data2 = (addr2 <= LAST_IDX) ? mem[addr2] : '0;

    assign in_ready    = in_ready_q;
    assign frame_ready = frame_ready_q;
    assign frame_err   = frame_err_q;
    assign wr_count    = wr_count_q;

endmodule

// File: tb/tb_conv_image_buffer.sv
// Testbench for conv_image_buffer: fixed read-vector table, hand-written corner
// sequences and a randomized phase, all checked against a frame-level model.
module tb_conv_image_buffer;

    localparam int NPIX   = 784;
    localparam int ADDR_W = 10;
    localparam int MEMSZ  = 1 << ADDR_W;

    logic                    clk = 1'b0;
    logic                    rst = 1'b0;
    logic signed [7:0]       in_data = '0;
    logic                    in_valid = 1'b0;
    logic                    in_last = 1'b0;
    logic                    in_ready;
    logic                    frame_ready;
    logic                    frame_err;
    logic [ADDR_W-1:0]       wr_count;
    logic                    release_frame = 1'b0;
    logic [ADDR_W-1:0]       addr1 = '0;
    logic [ADDR_W-1:0]       addr2 = '0;
    logic signed [7:0]       data1;
    logic signed [7:0]       data2;

    conv_image_buffer #(
        .IMG_W (28),
        .IMG_H (28),
        .ADDR_W(ADDR_W),
        .DATA_W(8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_last      (in_last),
        .in_ready     (in_ready),
        .frame_ready  (frame_ready),
        .frame_err    (frame_err),
        .wr_count     (wr_count),
        .release_frame(release_frame),
        .addr1        (addr1),
        .addr2        (addr2),
        .data1        (data1),
        .data2        (data2)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Frame-level reference: pixels written so far, frame held or not, error flag.
    bit                m_ready = 1'b0;
    bit                m_full  = 1'b0;
    bit                m_err   = 1'b0;
    int                m_count = 0;
    logic signed [7:0] m_mem   [0:MEMSZ-1];
    bit                m_known [0:MEMSZ-1];

    typedef struct {
        int a1;
        int a2;
        int e1;
        int e2;
    } rvec_t;

    rvec_t tbl [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit read_known(input int a);
        return (a >= NPIX) || m_known[a];
    endfunction

    function automatic logic signed [7:0] model_read(input int a);
        if (a >= NPIX) return 8'sd0;
        return m_mem[a];
    endfunction

    function automatic int raddr();
        return int'($urandom_range(MEMSZ - 1, 0));
    endfunction

    task automatic check_reads(input string tag);
        if (read_known(int'(addr1))) check({tag, "_data1"}, data1, model_read(int'(addr1)));
        if (read_known(int'(addr2))) check({tag, "_data2"}, data2, model_read(int'(addr2)));
    endtask

    // Apply one clock edge to the model using the inputs currently driven.
    task automatic model_edge();
        bit was_ready;
        if (!rst) begin
            m_ready = 1'b0;
            m_full  = 1'b0;
            m_count = 0;
            m_err   = 1'b0;
        end else if (m_full) begin
            if (release_frame) begin
                m_full  = 1'b0;
                m_count = 0;
                m_err   = 1'b0;
                m_ready = 1'b1;
            end
        end else begin
            was_ready = m_ready;
            m_ready   = 1'b1;
            if (in_valid && was_ready) begin
                m_mem[m_count]   = in_data;
                m_known[m_count] = 1'b1;
                m_count++;
                if (in_last || (m_count == NPIX)) begin
                    m_full  = 1'b1;
                    m_ready = 1'b0;
                    if (in_last != (m_count == NPIX)) m_err = 1'b1;
                end
            end
        end
    endtask

    // Drive one cycle of inputs, check reads before and everything after the edge.
    task automatic step(input bit v, input logic [7:0] d, input bit l, input bit rel,
                        input int a1, input int a2);
        in_valid      = v;
        in_data       = d;
        in_last       = l;
        release_frame = rel;
        addr1         = a1[ADDR_W-1:0];
        addr2         = a2[ADDR_W-1:0];
        #1;
        check_reads("pre");
        @(posedge clk);
        model_edge();
        #1;
        check("in_ready", in_ready, m_ready);
        check("frame_ready", frame_ready, m_full);
        check("frame_err", frame_err, m_err);
        check("wr_count", wr_count, m_count);
        check_reads("post");
    endtask

    task automatic idle();
        step(1'b0, 8'h00, 1'b0, 1'b0, raddr(), raddr());
    endtask

    task automatic release_pulse();
        step(1'b0, 8'h00, 1'b0, 1'b1, raddr(), raddr());
        check("rel_in_ready", in_ready, 1);
        check("rel_wr_count", wr_count, 0);
        check("rel_frame_ready", frame_ready, 0);
        check("rel_frame_err", frame_err, 0);
    endtask

    initial begin
        for (int i = 0; i < MEMSZ; i++) m_known[i] = 1'b0;

        tbl[0]  = '{0, 783, 0, 15};
        tbl[1]  = '{784, 1023, 0, 0};
        tbl[2]  = '{100, 100, 100, 100};
        tbl[3]  = '{127, 128, 127, 0};
        tbl[4]  = '{129, 500, 1, 116};
        tbl[5]  = '{1000, 27, 0, 27};
        tbl[6]  = '{0, 1, 0, 1};
        tbl[7]  = '{2, 28, 2, 28};
        tbl[8]  = '{29, 30, 29, 30};
        tbl[9]  = '{56, 57, 56, 57};
        tbl[10] = '{58, 58, 58, 58};
        tbl[11] = '{255, 256, 127, 0};

        // Reset state while rst is held low.
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 0);
        check("rst_frame_ready", frame_ready, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_wr_count", wr_count, 0);
        rst = 1'b1;
        idle();
        check("in_ready_after_rst", in_ready, 1);
        $display("reset: in_ready=%0d wr_count=%0d", in_ready, wr_count);

        // Full frame, value = addr mod 128, in_last on the final pixel.
        for (int i = 0; i < NPIX; i++) begin
            step(1'b1, 8'(i % 128), i == NPIX - 1, 1'b0, raddr(), raddr());
        end
        check("frame_full_ready", frame_ready, 1);
        check("frame_full_err", frame_err, 0);
        check("frame_full_count", wr_count, 784);
        check("frame_full_in_ready", in_ready, 0);
        $display("frame1: ready=%0d err=%0d count=%0d", frame_ready, frame_err, wr_count);

        // Read-port vector table, including the top-left 3x3 patch addresses.
        for (int k = 0; k < 12; k++) begin
            addr1 = tbl[k].a1[ADDR_W-1:0];
            addr2 = tbl[k].a2[ADDR_W-1:0];
            @(posedge clk);
            #1;
            check("tbl_data1", data1, tbl[k].e1);
            check("tbl_data2", data2, tbl[k].e2);
            $display("read vec %0d: addr1=%0d data1=%0d addr2=%0d data2=%0d",
                     k, tbl[k].a1, data1, tbl[k].a2, data2);
        end

        // Held frame ignores in_valid; memory must not change.
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 8'h7F, 1'b0, 1'b0, raddr(), raddr());
        end
        addr1 = 10'd5;
        addr2 = 10'd783;
        #1;
        check("hold_data1", data1, 5);
        check("hold_data2", data2, 15);
        check("hold_count", wr_count, 784);
        release_pulse();
        $display("hold+release: in_ready=%0d wr_count=%0d", in_ready, wr_count);

        // Early in_last on beat 10.
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 8'($urandom), i == 9, 1'b0, raddr(), raddr());
        end
        check("early_last_err", frame_err, 1);
        check("early_last_count", wr_count, 10);
        check("early_last_ready", frame_ready, 1);
        $display("early last: err=%0d count=%0d", frame_err, wr_count);
        release_pulse();

        // Missing in_last on the final pixel.
        for (int i = 0; i < NPIX; i++) begin
            step(1'b1, 8'($urandom), 1'b0, 1'b0, raddr(), raddr());
        end
        check("no_last_err", frame_err, 1);
        check("no_last_count", wr_count, 784);
        check("no_last_ready", frame_ready, 1);
        $display("missing last: err=%0d count=%0d", frame_err, wr_count);
        release_pulse();

        // Asynchronous reset mid-fill, then a clean refill.
        for (int i = 0; i < 300; i++) begin
            step(1'b1, 8'($urandom), 1'b0, 1'b0, raddr(), i);
        end
        check("midfill_count", wr_count, 300);
        rst = 1'b0;
        #1;
        check("async_rst_count", wr_count, 0);
        check("async_rst_in_ready", in_ready, 0);
        check("async_rst_frame_ready", frame_ready, 0);
        m_ready = 1'b0;
        m_full  = 1'b0;
        m_count = 0;
        m_err   = 1'b0;
        idle();
        rst = 1'b1;
        idle();
        check("post_rst_in_ready", in_ready, 1);
        for (int i = 0; i < NPIX; i++) begin
            step(1'b1, 8'($urandom), i == NPIX - 1, 1'b0, raddr(), i);
        end
        check("refill_err", frame_err, 0);
        check("refill_ready", frame_ready, 1);
        check("refill_count", wr_count, 784);
        $display("reset mid-fill + refill: err=%0d count=%0d", frame_err, wr_count);
        release_pulse();

        // Randomized traffic: gaps, rare early in_last, stray release pulses.
        for (int c = 0; c < 6000; c++) begin
            bit v;
            bit l;
            bit r;
            int a2;
            v  = ($urandom_range(3, 0) != 0);
            l  = v && ($urandom_range(299, 0) == 0);
            r  = ($urandom_range(9, 0) == 0);
            a2 = ($urandom_range(1, 0) == 0) ? m_count : raddr();
            step(v, 8'($urandom), l, r, raddr(), a2);
        end
        $display("random phase done: count=%0d full=%0d", wr_count, frame_ready);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
